pipe_stage_reg: RTL and testbench

- Parametrised pipeline latch. Generalises the fixed FD/DX/XM/MW/PW stage registers into one configurable block.
- Per-stage content:
  - instruction word
  - NUM_FIELDS data fields of DATA_W bits
  - valid bit
- Controls: stall (hold), flush (NOP insertion) and multicycle occupancy (hold until the functional unit reports done, with timeout).
- Instantiated between every pair of pipeline stages, and on the multiply/divide writeback path.

---
 rtl/pipe_stage_reg_if.sv | 33 +++
 rtl/pipe_stage_reg.sv | 122 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - pipeline stage upstream/downstream signal bundle
interface pipe_stage_reg_if #(
  parameter int DATA_W     = 32,
  parameter int NUM_FIELDS = 3
);
  logic                         in_valid;
  logic [DATA_W-1:0]            in_ir;
  logic [NUM_FIELDS*DATA_W-1:0] in_fields;
  logic                         stall;
  logic                         flush;
  logic                         mc_start;
  logic                         mc_ready;
  logic                         out_valid;
  logic [DATA_W-1:0]            out_ir;
  logic [NUM_FIELDS*DATA_W-1:0] out_fields;
  logic                         busy;
  logic                         mc_done;
  logic                         mc_timeout;
  logic [31:0]                  perf_stall_cnt;
  logic [31:0]                  perf_bubble_cnt;

  modport master (
    output in_valid, in_ir, in_fields, stall, flush, mc_start, mc_ready,
    input  out_valid, out_ir, out_fields, busy, mc_done, mc_timeout,
           perf_stall_cnt, perf_bubble_cnt
  );

  modport slave (
    input  in_valid, in_ir, in_fields, stall, flush, mc_start, mc_ready,
    output out_valid, out_ir, out_fields, busy, mc_done, mc_timeout,
           perf_stall_cnt, perf_bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - falling-edge pipeline latch with stall/flush and multicycle hold
// Optional perf counters built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int                DATA_W     = 32,
  parameter int                NUM_FIELDS = 3,
  parameter logic [DATA_W-1:0] NOP_WORD   = '0,
  parameter int                MC_TIMEOUT = 64
) (
  input  logic            clock,
  input  logic            reset,
  pipe_stage_reg_if.slave bus
);
  localparam logic [15:0] TO_LAST = 16'(MC_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic                         r_valid;
  logic [DATA_W-1:0]            r_ir;
  logic [NUM_FIELDS*DATA_W-1:0] r_fields;
  logic [15:0]                  r_cnt;
  logic                         r_rdy_q;
  logic                         r_timeout;
  logic                         w_load;
  logic                         w_bubble;
  logic                         w_to_abort;
  logic                         w_cnt_clr;
  logic                         w_cnt_inc;

  always_ff @(negedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // BUSY ignores stall; DONE otherwise behaves exactly like IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_bubble    = 1'b0;
    w_to_abort  = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    if (bus.flush) begin
      w_state_nxt = ST_IDLE;
      w_bubble    = 1'b1;
      w_cnt_clr   = 1'b1;
    end else if (r_state == ST_BUSY) begin
      if (r_rdy_q) begin
        w_state_nxt = ST_DONE;
      end else if (r_cnt == TO_LAST) begin
        w_state_nxt = ST_IDLE;
        w_to_abort  = 1'b1;
        w_cnt_clr   = 1'b1;
      end else begin
        w_cnt_inc = 1'b1;
      end
    end else if (bus.stall) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_load      = 1'b1;
      w_state_nxt = ST_IDLE;
      if (bus.in_valid && bus.mc_start) begin
        w_state_nxt = ST_BUSY;
        w_cnt_clr   = 1'b1;
      end
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_ir      <= NOP_WORD;
      r_fields  <= '0;
      r_cnt     <= '0;
      r_rdy_q   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      // ready only counts when sampled while the op stays in BUSY
      r_rdy_q <= (r_state == ST_BUSY && w_state_nxt == ST_BUSY) ? bus.mc_ready : 1'b0;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 16'd1;
      if (w_to_abort) r_timeout <= 1'b1;
      if (w_bubble || w_to_abort) begin
        r_valid <= 1'b0;
        r_ir    <= NOP_WORD;
      end else if (w_load) begin
        r_valid  <= bus.in_valid;
        r_ir     <= bus.in_ir;
        r_fields <= bus.in_fields;
      end
    end
  end

  assign bus.out_valid  = r_valid;
  assign bus.out_ir     = r_ir;
  assign bus.out_fields = r_fields;
  assign bus.busy       = (r_state == ST_BUSY);
  assign bus.mc_done    = (r_state == ST_DONE);
  assign bus.mc_timeout = r_timeout;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_bubble;

  always_ff @(negedge clock) begin
    if (reset) begin
      r_perf_stall  <= '0;
      r_perf_bubble <= '0;
    end else begin
      if (r_state == ST_IDLE && bus.stall && !bus.flush) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_bubble || w_to_abort) r_perf_bubble <= r_perf_bubble + 32'd1;
    end
  end

  assign bus.perf_stall_cnt  = r_perf_stall;
  assign bus.perf_bubble_cnt = r_perf_bubble;
`else
  assign bus.perf_stall_cnt  = '0;
  assign bus.perf_bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;
  localparam int          DW  = 32;
  localparam int          NF  = 3;
  localparam int          TO  = 20;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    bit          valid;
    logic [31:0] ir;
    logic [95:0] fields;
    bit          busy;
    bit          done;
    bit          to;
    logic [31:0] ps;
    logic [31:0] pb;
  } exp_t;

  logic clock = 1'b1;
  logic reset = 1'b1;
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  bit          m_valid, m_active, m_done, m_rdy, m_to;
  logic [31:0] m_ir, m_ps, m_pb;
  logic [95:0] m_f;
  int          m_age;
  int          rdy_pct;

  pipe_stage_reg_if #(.DATA_W(DW), .NUM_FIELDS(NF)) bus();

  pipe_stage_reg #(
    .DATA_W(DW), .NUM_FIELDS(NF), .NOP_WORD(NOP), .MC_TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the stage either holds a multicycle op (aging until ready or
  // expiry), has just released one, or is a plain latch.
  task automatic model_step();
    bit was_done = m_done;
    if (reset) begin
      m_valid = 0; m_ir = NOP; m_f = '0; m_active = 0; m_done = 0;
      m_rdy = 0; m_to = 0; m_age = 0; m_ps = 0; m_pb = 0;
      return;
    end
    m_done = 0;
    if (bus.flush) begin
      m_valid = 0; m_ir = NOP; m_active = 0; m_rdy = 0; m_pb = m_pb + 1;
    end else if (m_active) begin
      if (m_rdy) begin
        m_active = 0; m_done = 1; m_rdy = 0;
      end else if (m_age == TO - 1) begin
        m_active = 0; m_to = 1; m_valid = 0; m_ir = NOP; m_pb = m_pb + 1;
      end else begin
        m_age++;
        m_rdy = bus.mc_ready;
      end
    end else if (bus.stall) begin
      if (!was_done) m_ps = m_ps + 1;
    end else begin
      m_valid = bus.in_valid; m_ir = bus.in_ir; m_f = bus.in_fields;
      if (bus.in_valid && bus.mc_start) begin
        m_active = 1; m_age = 0; m_rdy = 0;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    exp_q.push_back('{m_valid, m_ir, m_f, m_active, m_done, m_to, m_ps, m_pb});
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ir, input bit st, input bit fl,
                       input bit ms, input bit mr);
    bus.in_valid  = v;
    bus.in_ir     = ir;
    bus.in_fields = {$urandom, $urandom, $urandom};
    bus.stall     = st;
    bus.flush     = fl;
    bus.mc_start  = ms;
    bus.mc_ready  = mr;
    cycle();
  endtask

  initial begin
    forever begin
      @(posedge clock);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("out_valid",  {95'd0, bus.out_valid},  {95'd0, mon_e.valid});
        chk("out_ir",     {64'd0, bus.out_ir},     {64'd0, mon_e.ir});
        chk("out_fields", bus.out_fields,          mon_e.fields);
        chk("busy",       {95'd0, bus.busy},       {95'd0, mon_e.busy});
        chk("mc_done",    {95'd0, bus.mc_done},    {95'd0, mon_e.done});
        chk("mc_timeout", {95'd0, bus.mc_timeout}, {95'd0, mon_e.to});
`ifdef PIPE_STAGE_PERF_EN
        chk("perf_stall",  {64'd0, bus.perf_stall_cnt},  {64'd0, mon_e.ps});
        chk("perf_bubble", {64'd0, bus.perf_bubble_cnt}, {64'd0, mon_e.pb});
`else
        chk("perf_stall",  {64'd0, bus.perf_stall_cnt},  96'd0);
        chk("perf_bubble", {64'd0, bus.perf_bubble_cnt}, 96'd0);
`endif
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive(0, 32'h0, 0, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 0, 0);
    reset = 1'b0;

    // plain load, stall, flush-with-stall
    bus.in_fields = {32'h30, 32'h20, 32'h10};
    bus.in_valid = 1; bus.in_ir = 32'h0822_0005;
    bus.stall = 0; bus.flush = 0; bus.mc_start = 0; bus.mc_ready = 0;
    cycle();
    repeat (3) drive(1, 32'hDEAD_BEEF, 1, 0, 0, 0);
    drive(1, 32'hDEAD_BEEF, 1, 1, 0, 0);

    // multicycle op, ready raised after 17 cycles, stall ignored in BUSY
    drive(1, 32'h0200_0033, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) drive(1, 32'h1111_0000 + i, i[0], 0, 0, 0);
    drive(1, 32'h2222_0000, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 32'h3333_0000 + i, 0, 0, 0, 0);

    // timeout with ready held low
    drive(1, 32'h0200_4033, 0, 0, 1, 0);
    for (int i = 0; i < TO + 2; i++) drive(1, 32'h4444_0000 + i, 0, 0, 0, 0);

    // ready sampled on the last possible BUSY edge beats expiry
    drive(1, 32'h0200_5033, 0, 0, 1, 0);
    for (int i = 0; i < TO - 2; i++) drive(1, 32'h5555_0000 + i, 0, 0, 0, 0);
    drive(1, 32'h5555_FFFF, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 32'h6666_0000 + i, 0, 0, 0, 0);

    // mc_start without valid, flush in BUSY, reset mid-BUSY
    drive(0, 32'h0200_6033, 0, 0, 1, 0);
    drive(1, 32'h0200_7033, 0, 0, 1, 0);
    repeat (3) drive(1, 32'h7777_0000, 0, 0, 0, 0);
    drive(1, 32'h7777_0001, 0, 1, 0, 0);
    drive(1, 32'h0200_8033, 0, 0, 1, 0);
    repeat (4) drive(1, 32'h8888_0000, 0, 0, 0, 0);
    reset = 1'b1;
    drive(1, 32'h8888_0001, 0, 0, 0, 0);
    reset = 1'b0;
    drive(1, 32'h8888_0002, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      case ((i / 256) % 3)
        0:       rdy_pct = 0;
        1:       rdy_pct = 5;
        default: rdy_pct = 30;
      endcase
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < rdy_pct);
    end
    reset = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    chk("queue_drained", 96'(exp_q.size()), 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
